// File: rtl/dadda_seq_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier built around
// one 16x16 Dadda multiplier.
package dadda_seq_pkg;

    localparam int OP_W   = 32;
    localparam int HALF_W = 16;
    localparam int RES_W  = 64;

    localparam logic [1:0] STEP_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Weight of each partial product inside the 64-bit result.
    function automatic logic [5:0] step_shift(input logic [1:0] step);
        case (step)
            2'd0:    step_shift = 6'd0;
            2'd1:    step_shift = 6'd16;
            2'd2:    step_shift = 6'd16;
            default: step_shift = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/Dadda_16b.sv
// Combinational 16x16 unsigned multiplier: Dadda column reduction down to two
// rows followed by a single carry-propagate adder.
module Dadda_16b
    import dadda_seq_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    localparam int N      = HALF_W;
    localparam int W      = 2 * HALF_W;
    localparam int STAGES = 6;

    // Dadda height limits for a 16-row tree: 13, 9, 6, 4, 3, 2.
    function automatic int stage_target(input int s);
        case (s)
            0:       stage_target = 13;
            1:       stage_target = 9;
            2:       stage_target = 6;
            3:       stage_target = 4;
            4:       stage_target = 3;
            default: stage_target = 2;
        endcase
    endfunction

    always_comb begin
        // Column W is a sink for carries out of the MSB; the product fits in W bits.
        logic [N-1:0] cur   [W+1];
        logic [N-1:0] nxt   [W+1];
        int           cur_h [W+1];
        int           nxt_h [W+1];
        logic [W-1:0] row0;
        logic [W-1:0] row1;
        logic         sum;
        logic         carry;
        int           d;
        int           pos;
        int           eff;

        for (int i = 0; i <= W; i++) begin
            cur[i]   = '0;
            cur_h[i] = 0;
            nxt[i]   = '0;
            nxt_h[i] = 0;
        end
        sum   = 1'b0;
        carry = 1'b0;
        d     = 0;
        pos   = 0;
        eff   = 0;

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                cur[i+j][4'(cur_h[i+j])] = a[i] & b[j];
                cur_h[i+j]++;
            end
        end

        for (int s = 0; s < STAGES; s++) begin
            d = stage_target(s);
            for (int i = 0; i <= W; i++) begin
                nxt[i]   = '0;
                nxt_h[i] = 0;
            end
            for (int i = 0; i < W; i++) begin
                pos = 0;
                // Carries already pushed into nxt[i] count toward the column height.
                for (int k = 0; k < N; k++) begin
                    eff = (cur_h[i] - pos) + nxt_h[i];
                    if (eff > d) begin
                        if (eff - d == 1) begin
                            sum   = cur[i][4'(pos)] ^ cur[i][4'(pos+1)];
                            carry = cur[i][4'(pos)] & cur[i][4'(pos+1)];
                            pos   = pos + 2;
                        end else begin
                            sum   = cur[i][4'(pos)] ^ cur[i][4'(pos+1)] ^ cur[i][4'(pos+2)];
                            carry = (cur[i][4'(pos)]   & cur[i][4'(pos+1)]) |
                                    (cur[i][4'(pos)]   & cur[i][4'(pos+2)]) |
                                    (cur[i][4'(pos+1)] & cur[i][4'(pos+2)]);
                            pos   = pos + 3;
                        end
                        nxt[i][4'(nxt_h[i])] = sum;
                        nxt_h[i]++;
                        nxt[i+1][4'(nxt_h[i+1])] = carry;
                        nxt_h[i+1]++;
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (k >= pos && k < cur_h[i]) begin
                        nxt[i][4'(nxt_h[i])] = cur[i][k];
                        nxt_h[i]++;
                    end
                end
            end
            cur   = nxt;
            cur_h = nxt_h;
        end

        for (int i = 0; i < W; i++) begin
            row0[i] = cur[i][0];
            row1[i] = cur[i][1];
        end
        p = row0 + row1;
    end

endmodule

// File: rtl/dadda_mul32_seq.sv
// Sequenced 32x32 unsigned multiplier sharing one Dadda_16b over four steps.
// Define DADDA_SEQ_PIPE_EN to register the multiplier output (one extra cycle).
module dadda_mul32_seq
    import dadda_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [RES_W-1:0] Y
);

    state_t              state;
    logic [1:0]          step;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic [RES_W-1:0]    acc;
    logic [HALF_W-1:0]   mul_a;
    logic [HALF_W-1:0]   mul_b;
    logic [2*HALF_W-1:0] pp;

`ifdef DADDA_SEQ_PIPE_EN
    logic [2*HALF_W-1:0] pp_q;
    logic [5:0]          shift_q;
    logic                pipe_full;
    logic                last_q;
`endif

    // Step 1 takes the high half of B, step 2 the high half of A, step 3 both.
    always_comb begin
        // NOTE: defaults first so every path assigns both halves; no latch is inferred.
        mul_a = a_q[HALF_W-1:0];
        mul_b = b_q[HALF_W-1:0];
        case (step)
            2'd1: mul_b = b_q[OP_W-1:HALF_W];
            2'd2: mul_a = a_q[OP_W-1:HALF_W];
            2'd3: begin
                mul_a = a_q[OP_W-1:HALF_W];
                mul_b = b_q[OP_W-1:HALF_W];
            end
            default: ;
        endcase
    end

    Dadda_16b u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (RST) begin
            state     <= ST_IDLE;
            step      <= '0;
            acc       <= '0;
            // NOTE: operand registers are cleared too, keeping the multiplier
            // inputs deterministic straight out of reset.
            a_q       <= '0;
            b_q       <= '0;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
`ifdef DADDA_SEQ_PIPE_EN
            pp_q      <= '0;
            shift_q   <= '0;
            pipe_full <= 1'b0;
            last_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        a_q      <= A;
                        b_q      <= B;
                        acc      <= '0;
                        step     <= '0;
                        state    <= ST_MUL;
                        IN_READY <= 1'b0;
`ifdef DADDA_SEQ_PIPE_EN
                        pipe_full <= 1'b0;
                        last_q    <= 1'b0;
`endif
                    end
                end

                ST_MUL: begin
`ifdef DADDA_SEQ_PIPE_EN
                    // Issue the current step into the pipe while the previous one accumulates.
                    pp_q      <= pp;
                    shift_q   <= step_shift(step);
                    last_q    <= (step == STEP_LAST);
                    pipe_full <= 1'b1;
                    if (step != STEP_LAST) begin
                        step <= step + 2'd1;
                    end
                    if (pipe_full) begin
                        acc <= acc + (RES_W'(pp_q) << shift_q);
                        if (last_q) begin
                            state     <= ST_DONE;
                            OUT_VALID <= 1'b1;
                        end
                    end
`else
                    acc <= acc + (RES_W'(pp) << step_shift(step));
                    if (step == STEP_LAST) begin
                        state     <= ST_DONE;
                        OUT_VALID <= 1'b1;
                    end else begin
                        step <= step + 2'd1;
                    end
`endif
                end

                ST_DONE: begin
                    if (OUT_READY) begin
                        state     <= ST_IDLE;
                        step      <= '0;
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    IN_READY  <= 1'b1;
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

    assign Y = acc;

endmodule

// File: tb/tb_dadda_mul32_seq.sv
// Self-checking bench for dadda_mul32_seq: directed vector table plus
// hand-written stall, reset and back-to-back sequences.
module tb_dadda_mul32_seq;

`ifdef DADDA_SEQ_PIPE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    localparam int PERIOD = LAT + 2;
    localparam int NVEC   = 8;
    localparam int NRAND  = 100;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] y;
        bit          zap;
        string       name;
    } vec_t;

    vec_t vecs [NVEC];

    dadda_mul32_seq dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .A         (a),
        .B         (b),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .Y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Counts clock edges until OUT_VALID; a timeout shows up as a wrong latency.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input vec_t v);
        int cyc;
        check({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
        a         = v.a;
        b         = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (v.zap) begin
            a = '0;
            b = '0;
        end
        wait_out(cyc);
        check({v.name, "_latency"}, 64'(cyc), 64'(LAT));
        check({v.name, "_y"}, y, v.y);
        @(posedge clk); #1;
        check({v.name, "_idle"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        int          cyc;
        bit          stall_ok;
        int          sent;
        int          got;
        int          last_ready;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp_q [$];
        logic [63:0] exp_y;

        vecs[0] = '{32'h00020003, 32'h00040005, 64'h000000080016000F, 1'b0, "basic"};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, "all_ones"};
        vecs[2] = '{32'h0000FFFF, 32'h00010001, 64'h00000000FFFFFFFF, 1'b1, "capture"};
        vecs[3] = '{32'h12345678, 32'h00000000, 64'h0000000000000000, 1'b0, "zero"};
        vecs[4] = '{32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF, 1'b0, "one"};
        vecs[5] = '{32'h80000000, 32'h00000002, 64'h0000000100000000, 1'b0, "msb"};
        vecs[6] = '{32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b0, "hi_hi"};
        vecs[7] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 1'b0, "lo_lo"};

        // Reset with IN_VALID asserted: the request must be ignored.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 32'hDEADBEEF;
        b         = 32'h00000007;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_y", y, 64'd0);

        for (int i = 0; i < NVEC; i++) run_op(vecs[i]);

        // Output stall: result held, new request refused until the handshake.
        a         = 32'h00020003;
        b         = 32'h00040005;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(cyc);
        check("stall_latency", 64'(cyc), 64'(LAT));
        check("stall_y", y, 64'h000000080016000F);
        a        = 32'd7;
        b        = 32'd9;
        in_valid = 1'b1;
        stall_ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (y !== 64'h000000080016000F || in_ready !== 1'b0 || out_valid !== 1'b1)
                stall_ok = 1'b0;
        end
        check("stall_hold", 64'(stall_ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(cyc);
        check("after_stall_latency", 64'(cyc), 64'(LAT));
        check("after_stall_y", y, 64'd63);
        @(posedge clk); #1;

        // Reset while step 2 is in flight.
        a        = 32'h12345678;
        b        = 32'h9ABCDEF0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_y", y, 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        run_op('{32'd3, 32'd5, 64'd15, 1'b0, "post_reset"});

        // Back-to-back random operands with both handshakes held high.
        sent       = 0;
        got        = 0;
        last_ready = -1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int c = 0; c < NRAND * (PERIOD + 2) + 50 && got < NRAND; c++) begin
            if (in_ready === 1'b1) begin
                if (sent < NRAND) begin
                    ra = $urandom;
                    rb = $urandom;
                    a  = ra;
                    b  = rb;
                    exp_q.push_back(64'(ra) * 64'(rb));
                    if (last_ready >= 0) check("b2b_period", 64'(c - last_ready), 64'(PERIOD));
                    last_ready = c;
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
                check("b2b_y", y, exp_y);
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("b2b_count", 64'(got), 64'(NRAND));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
